// File: rtl/mdu_writeback.sv
//==============================================================================
// Module   : mdu_writeback
// Function : Iterative unsigned multiply/divide unit. It accepts
//            MUL/MULHU/DIVU/REMU, computes one result bit per cycle and holds
//            the result until the shared register-file write port is granted.
// Options  : MDU_EARLY_OUT_EN - a multiply finishes as soon as no multiplier
//            bits remain set.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module mdu_writeback #(
    parameter int BIT_WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [1:0]           op,
    input  logic [BIT_WIDTH-1:0] src_a,
    input  logic [BIT_WIDTH-1:0] src_b,
    input  logic [3:0]           dst_in,
    input  logic                 wb_grant,
    output logic                 busy,
    output logic                 result_valid,
    output logic                 wrt_en,
    output logic [3:0]           dst,
    output logic [BIT_WIDTH-1:0] dst_data
);

    localparam int CNT_W = (BIT_WIDTH > 1) ? $clog2(BIT_WIDTH) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BIT_WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_WB   = 2'd2
    } state_t;

    state_t                   state_q, state_d;
    logic [1:0]               op_q, op_d;
    logic [3:0]               dst_q, dst_d;
    logic [CNT_W-1:0]         cnt_q, cnt_d;
    // a_q: multiplicand, shifted left each multiply cycle
    logic [2*BIT_WIDTH-1:0]   a_q, a_d;
    // b_q: multiplier (shifted right) or divisor (held)
    logic [BIT_WIDTH-1:0]     b_q, b_d;
    // acc_q: product for multiply, {remainder, quotient/dividend} for divide
    logic [2*BIT_WIDTH-1:0]   acc_q, acc_d;

    // One restoring-division step: bring in the next dividend bit and trial-subtract.
    logic [BIT_WIDTH:0]       div_shift;
    logic [BIT_WIDTH+1:0]     div_diff;
    logic                     div_ok;
    logic [BIT_WIDTH-1:0]     div_rem;
    logic [2*BIT_WIDTH-1:0]   mul_sum;
    logic [BIT_WIDTH-1:0]     b_shr;

    assign div_shift = {acc_q[2*BIT_WIDTH-1:BIT_WIDTH], acc_q[BIT_WIDTH-1]};
    assign div_diff  = {1'b0, div_shift} - {2'b00, b_q};
    assign div_ok    = ~div_diff[BIT_WIDTH+1];
    assign div_rem   = div_ok ? div_diff[BIT_WIDTH-1:0] : div_shift[BIT_WIDTH-1:0];
    assign mul_sum   = acc_q + (b_q[0] ? a_q : '0);
    assign b_shr     = b_q >> 1;

    // State and datapath registers; reset discards any in-flight operation.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            op_q    <= '0;
            dst_q   <= '0;
            cnt_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            acc_q   <= '0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            dst_q   <= dst_d;
            cnt_q   <= cnt_d;
            a_q     <= a_d;
            b_q     <= b_d;
            acc_q   <= acc_d;
        end
    end

    // Next-state and datapath update for launch, iteration and writeback.
    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        dst_d   = dst_q;
        cnt_d   = cnt_q;
        a_d     = a_q;
        b_d     = b_q;
        acc_d   = acc_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    op_d  = op;
                    dst_d = dst_in;
                    a_d   = {{BIT_WIDTH{1'b0}}, src_a};
                    b_d   = src_b;
                    cnt_d = '0;
                    if (op[1]) begin
                        // Dividend sits in the low half and shifts out MSB first.
                        acc_d   = {{BIT_WIDTH{1'b0}}, src_a};
                        state_d = S_RUN;
                        if (src_b == '0) begin
                            // Divide by zero: quotient all ones, remainder = dividend.
                            acc_d   = {src_a, {BIT_WIDTH{1'b1}}};
                            state_d = S_WB;
                        end
                    end else begin
                        acc_d   = '0;
                        state_d = S_RUN;
`ifdef MDU_EARLY_OUT_EN
                        if (src_b == '0) begin
                            state_d = S_WB;
                        end
`endif
                    end
                end
            end

            S_RUN: begin
                cnt_d = cnt_q + 1'b1;
                if (op_q[1]) begin
                    acc_d = {div_rem, acc_q[BIT_WIDTH-2:0], div_ok};
                end else begin
                    acc_d = mul_sum;
                    a_d   = a_q << 1;
                    b_d   = b_shr;
                end
                if (cnt_q == CNT_LAST) begin
                    state_d = S_WB;
                end
`ifdef MDU_EARLY_OUT_EN
                if (!op_q[1] && (b_shr == '0)) begin
                    state_d = S_WB;
                end
`endif
            end

            S_WB: begin
                if (wb_grant) begin
                    state_d = S_IDLE;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Odd opcodes (MULHU, REMU) take the upper half of the accumulator.
    assign busy         = (state_q != S_IDLE);
    assign result_valid = (state_q == S_WB);
    assign wrt_en       = result_valid & wb_grant;
    assign dst          = dst_q;
    assign dst_data     = result_valid ?
                          (op_q[0] ? acc_q[2*BIT_WIDTH-1:BIT_WIDTH] : acc_q[BIT_WIDTH-1:0]) :
                          '0;

endmodule

`default_nettype wire

// File: tb/tb_mdu_writeback.sv
//==============================================================================
// Module   : tb_mdu_writeback
// Function : Self-checking bench for mdu_writeback (directed vector table plus
//            hand-written grant-stall, reset and back-to-back sequences).
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_mdu_writeback;

    localparam int W = 32;

    logic         clk;
    logic         rst;
    logic         start;
    logic [1:0]   op;
    logic [W-1:0] src_a;
    logic [W-1:0] src_b;
    logic [3:0]   dst_in;
    logic         wb_grant;
    logic         busy;
    logic         result_valid;
    logic         wrt_en;
    logic [3:0]   dst;
    logic [W-1:0] dst_data;

    int checks;
    int failures;

    mdu_writeback #(.BIT_WIDTH(W)) u_dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .op           (op),
        .src_a        (src_a),
        .src_b        (src_b),
        .dst_in       (dst_in),
        .wb_grant     (wb_grant),
        .busy         (busy),
        .result_valid (result_valid),
        .wrt_en       (wrt_en),
        .dst          (dst),
        .dst_data     (dst_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]   op;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [3:0]   d;
        logic [W-1:0] exp;
    } vec_t;

    vec_t vecs[15];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, req);
        end
    endtask

    // Cycles after the launch edge until result_valid is seen.
    function automatic int exp_lat(input logic [1:0] o, input logic [W-1:0] b);
        int lat;
        lat = W;
        if (o[1]) begin
            if (b == '0) lat = 0;
        end else begin
`ifdef MDU_EARLY_OUT_EN
            lat = 0;
            for (int i = 0; i < W; i++) begin
                if (b[i]) lat = i + 1;
            end
`endif
        end
        return lat;
    endfunction

    task automatic run_op(input int idx, input logic [1:0] o, input logic [W-1:0] a,
                          input logic [W-1:0] b, input logic [3:0] d, input logic [W-1:0] req);
        int n;
        int early_wr;
        op     = o;
        src_a  = a;
        src_b  = b;
        dst_in = d;
        start  = 1'b1;
        tick();
        start  = 1'b0;
        src_a  = '0;
        src_b  = '0;
        dst_in = '0;
        n        = 0;
        early_wr = 0;
        while (!result_valid && n < 200) begin
            if (wrt_en) early_wr++;
            tick();
            n++;
        end
        check($sformatf("v%0d_latency", idx), 64'(n), 64'(exp_lat(o, b)));
        check($sformatf("v%0d_early_wrt_en", idx), 64'(early_wr), 64'd0);
        check($sformatf("v%0d_wrt_en", idx), 64'(wrt_en), 64'd1);
        check($sformatf("v%0d_dst", idx), 64'(dst), 64'(d));
        check($sformatf("v%0d_dst_data", idx), 64'(dst_data), 64'(req));
        tick();
        check($sformatf("v%0d_busy_after", idx), 64'(busy), 64'd0);
        check($sformatf("v%0d_wrt_en_after", idx), 64'(wrt_en), 64'd0);
        check($sformatf("v%0d_data_after", idx), 64'(dst_data), 64'd0);
    endtask

    initial begin
        int n;
        int cnt_wr;
        int cnt_idle;
        int lat;
        logic [W-1:0] held_data;
        logic [3:0]   held_dst;

        checks   = 0;
        failures = 0;

        vecs[0]  = '{2'b00, 32'd7,          32'd6,          4'd3,  32'd42};
        vecs[1]  = '{2'b01, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  4'd1,  32'hFFFF_FFFE};
        vecs[2]  = '{2'b00, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  4'd2,  32'h0000_0001};
        vecs[3]  = '{2'b10, 32'd100,        32'd7,          4'd4,  32'd14};
        vecs[4]  = '{2'b11, 32'd100,        32'd7,          4'd5,  32'd2};
        vecs[5]  = '{2'b10, 32'd5,          32'd0,          4'd6,  32'hFFFF_FFFF};
        vecs[6]  = '{2'b11, 32'd5,          32'd0,          4'd7,  32'd5};
        vecs[7]  = '{2'b00, 32'd5,          32'd1,          4'd8,  32'd5};
        vecs[8]  = '{2'b01, 32'h8000_0000,  32'd4,          4'd9,  32'd2};
        vecs[9]  = '{2'b10, 32'hFFFF_FFFF,  32'd1,          4'd10, 32'hFFFF_FFFF};
        vecs[10] = '{2'b11, 32'hFFFF_FFFF,  32'd10,         4'd11, 32'd5};
        vecs[11] = '{2'b10, 32'hFFFF_FFFF,  32'd10,         4'd12, 32'h1999_9999};
        vecs[12] = '{2'b00, 32'h1234_5678,  32'd0,          4'd13, 32'd0};
        vecs[13] = '{2'b00, 32'h0001_0000,  32'h0001_0000,  4'd14, 32'd0};
        vecs[14] = '{2'b01, 32'h0001_0000,  32'h0001_0000,  4'd15, 32'd1};

        rst      = 1'b1;
        start    = 1'b0;
        op       = '0;
        src_a    = '0;
        src_b    = '0;
        dst_in   = '0;
        wb_grant = 1'b1;
        tick();
        tick();
        check("reset_busy",  64'(busy), 64'd0);
        check("reset_valid", 64'(result_valid), 64'd0);
        check("reset_wrt",   64'(wrt_en), 64'd0);
        check("reset_dst",   64'(dst), 64'd0);
        check("reset_data",  64'(dst_data), 64'd0);
        rst = 1'b0;
        tick();

        // Directed vectors with the write port always free.
        for (int i = 0; i < 15; i++) begin
            run_op(i, vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].d, vecs[i].exp);
        end

        // Grant withheld for 10 cycles in WB: result must hold steady.
        wb_grant = 1'b0;
        op = 2'b10; src_a = 32'd100; src_b = 32'd7; dst_in = 4'd9;
        start = 1'b1;
        tick();
        start = 1'b0;
        n = 0;
        while (!result_valid && n < 200) begin
            tick();
            n++;
        end
        check("stall_reached_wb", 64'(result_valid), 64'd1);
        held_data = dst_data;
        held_dst  = dst;
        check("stall_data", 64'(held_data), 64'd14);
        check("stall_dst",  64'(held_dst), 64'd9);
        cnt_wr = 0;
        cnt_idle = 0;
        for (int k = 0; k < 10; k++) begin
            tick();
            if (wrt_en || !result_valid) cnt_wr++;
            if (dst_data !== held_data || dst !== held_dst) cnt_idle++;
        end
        check("stall_no_write", 64'(cnt_wr), 64'd0);
        check("stall_stable",   64'(cnt_idle), 64'd0);
        wb_grant = 1'b1;
        #1;
        check("stall_grant_wrt", 64'(wrt_en), 64'd1);
        tick();
        check("stall_after_wrt",  64'(wrt_en), 64'd0);
        check("stall_after_busy", 64'(busy), 64'd0);

        // Asynchronous reset during RUN cycle 15 of a divide.
        op = 2'b10; src_a = 32'd100; src_b = 32'd7; dst_in = 4'd5;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int k = 0; k < 15; k++) tick();
        check("midrst_pre_busy", 64'(busy), 64'd1);
        #2;
        rst = 1'b1;
        #1;
        check("midrst_busy",  64'(busy), 64'd0);
        check("midrst_valid", 64'(result_valid), 64'd0);
        check("midrst_wrt",   64'(wrt_en), 64'd0);
        check("midrst_dst",   64'(dst), 64'd0);
        check("midrst_data",  64'(dst_data), 64'd0);
        tick();
        tick();
        rst = 1'b0;
        cnt_wr = 0;
        for (int k = 0; k < 40; k++) begin
            tick();
            if (wrt_en || busy) cnt_wr++;
        end
        check("midrst_no_write", 64'(cnt_wr), 64'd0);
        run_op(100, 2'b00, 32'd3, 32'd3, 4'd2, 32'd9);

        // start held high: exactly one launch per IDLE visit.
        op = 2'b00; src_a = 32'd7; src_b = 32'd6; dst_in = 4'd1;
        lat = exp_lat(2'b00, 32'd6);
        start = 1'b1;
        tick();
        cnt_wr = 0;
        cnt_idle = 0;
        for (int k = 1; k <= 2 * (lat + 2); k++) begin
            tick();
            if (wrt_en) begin
                cnt_wr++;
                check("held_data", 64'(dst_data), 64'd42);
            end
            if (!busy) cnt_idle++;
        end
        start = 1'b0;
        check("held_writes", 64'(cnt_wr), 64'd2);
        check("held_idle",   64'(cnt_idle), 64'd2);
        n = 0;
        while (busy && n < 200) begin
            tick();
            n++;
        end
        check("held_drain", 64'(busy), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Watchdog so the run always ends.
    initial begin
        #2000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

endmodule

`default_nettype wire
